id_ex_stage: RTL and testbench

- ID/EX pipeline register plus execute-side operand preparation.
- Captures decoded operands and control from ID. Applies EX/MEM and MEM/WB forwarding and decodes the 2-bit ALU select.
- Drives the A, B and select inputs of the 64-bit ALU (00 AND, 01 OR, 10 ADD; carry-in fixed 0). Forwards store data, rd and control to EX/MEM.
- Handles stall (hold) and flush (bubble) from the hazard unit.

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/fwd_mux.sv | 23 ++
 rtl/id_ex_stage.sv | 122 ++++++++++++
 tb/tb_id_ex_stage.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared ALU select, opcode and ALUOp constants plus the control bundle.
package pipe_pkg;
  localparam logic [1:0] ALU_AND = 2'b00;
  localparam logic [1:0] ALU_OR  = 2'b01;
  localparam logic [1:0] ALU_ADD = 2'b10;
  localparam logic [10:0] OP_ADD = 11'b10001011000;
  localparam logic [10:0] OP_SUB = 11'b11001011000;
  localparam logic [10:0] OP_AND = 11'b10001010000;
  localparam logic [10:0] OP_ORR = 11'b10101010000;
  localparam logic [1:0] AOP_MEM = 2'b00;
  localparam logic [1:0] AOP_CBZ = 2'b01;
  localparam logic [1:0] AOP_R   = 2'b10;
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
  } ctrl_t;
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: per-operand forwarding select; EX/MEM beats MEM/WB, XZR never matches.
module fwd_mux #(
  parameter int DW = 64,
  parameter int RW = 5,
  parameter int ZR = 31
) (
  input  logic [RW-1:0] idx,
  input  logic [DW-1:0] reg_data,
  input  logic          exm_reg_write,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_result,
  input  logic          mwb_reg_write,
  input  logic [RW-1:0] mwb_rd,
  input  logic [DW-1:0] mwb_result,
  output logic [DW-1:0] data
);
  logic live;
  always_comb begin
    live = idx != RW'(ZR);
    data = (live && exm_reg_write && exm_rd == idx) ? exm_result :
           (live && mwb_reg_write && mwb_rd == idx) ? mwb_result : reg_data;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with forwarding and ALU operand/select decode.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DW = 64,
  parameter int RW = 5,
  parameter int ZR = 31
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rn_data,
  input  logic [DW-1:0] id_rm_data,
  input  logic [DW-1:0] id_imm,
  input  logic [RW-1:0] id_rn,
  input  logic [RW-1:0] id_rm,
  input  logic [RW-1:0] id_rd,
  input  logic [1:0]    id_alu_op,
  input  logic          id_alu_src,
  input  logic [10:0]   id_opcode,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          id_mem_to_reg,
  input  logic          id_branch,
  input  logic          exm_reg_write,
  input  logic [RW-1:0] exm_rd,
  input  logic [DW-1:0] exm_result,
  input  logic          mwb_reg_write,
  input  logic [RW-1:0] mwb_rd,
  input  logic [DW-1:0] mwb_result,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [1:0]    alu_sel,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_rd,
  output logic          ex_valid,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic          ex_mem_to_reg,
  output logic          ex_branch,
  output logic          ex_illegal
);
  logic          valid, alu_src;
  ctrl_t         ctrl;
  logic [DW-1:0] rn_data, rm_data, imm, fwd_rn, fwd_rm, b0;
  logic [RW-1:0] rn, rm, rd;
  logic [1:0]    alu_op;
  logic [10:0]   opcode;
  logic          r_type, is_add, is_sub, is_and, is_orr, illegal, live;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      ctrl    <= '0;
      rn_data <= '0;
      rm_data <= '0;
      imm     <= '0;
      rn      <= '0;
      rm      <= '0;
      rd      <= '0;
      alu_op  <= '0;
      alu_src <= 1'b0;
      opcode  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= '0;
    end else if (!stall) begin
      valid   <= id_valid;
      ctrl    <= '{id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch};
      rn_data <= id_rn_data;
      rm_data <= id_rm_data;
      imm     <= id_imm;
      rn      <= id_rn;
      rm      <= id_rm;
      rd      <= id_rd;
      alu_op  <= id_alu_op;
      alu_src <= id_alu_src;
      opcode  <= id_opcode;
    end
  end
  fwd_mux #(.DW(DW), .RW(RW), .ZR(ZR)) u_fwd_rn (
    .idx(rn), .reg_data(rn_data),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .data(fwd_rn)
  );
  fwd_mux #(.DW(DW), .RW(RW), .ZR(ZR)) u_fwd_rm (
    .idx(rm), .reg_data(rm_data),
    .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
    .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd), .mwb_result(mwb_result),
    .data(fwd_rm)
  );
  // An empty stage drives all zeros so a bubble looks like reset downstream.
  always_comb begin
    r_type        = alu_op == AOP_R;
    is_add        = opcode == OP_ADD;
    is_sub        = opcode == OP_SUB;
    is_and        = opcode == OP_AND;
    is_orr        = opcode == OP_ORR;
    illegal       = alu_op == 2'b11 || (r_type && !(is_add || is_sub || is_and || is_orr));
    live          = valid && !illegal;
    b0            = alu_src ? imm : fwd_rm;
    alu_sel       = !live ? ALU_AND :
                    alu_op == AOP_MEM ? ALU_ADD :
                    alu_op == AOP_CBZ ? ALU_OR :
                    (is_add || is_sub) ? ALU_ADD : is_orr ? ALU_OR : ALU_AND;
    alu_a         = (!live || alu_op == AOP_CBZ) ? '0 : fwd_rn;
    alu_b         = !live ? '0 : alu_op == AOP_CBZ ? fwd_rm : (r_type && is_sub) ? -b0 : b0;
    ex_store_data = valid ? fwd_rm : '0;
    ex_rd         = valid ? rd : '0;
    ex_valid      = valid;
    ex_illegal    = valid && illegal;
    ex_reg_write  = live && ctrl.reg_write;
    ex_mem_read   = live && ctrl.mem_read;
    ex_mem_write  = live && ctrl.mem_write;
    ex_mem_to_reg = live && ctrl.mem_to_reg;
    ex_branch     = live && ctrl.branch;
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed plus random stimulus, scoreboard against a behavioural model.
module tb_id_ex_stage;
  typedef struct packed {
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] sd;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic        v, rw, mr, mw, mtr, br, ill;
  } exp_t;
  logic        clk = 1'b0, rst_n, stall, flush, id_valid, id_alu_src;
  logic [63:0] id_rn_data, id_rm_data, id_imm, exm_result, mwb_result;
  logic [4:0]  id_rn, id_rm, id_rd, exm_rd, mwb_rd;
  logic [1:0]  id_alu_op;
  logic [10:0] id_opcode;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch;
  logic        exm_reg_write, mwb_reg_write;
  logic [63:0] alu_a, alu_b, ex_store_data;
  logic [1:0]  alu_sel;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_illegal;
  int checks = 0, errors = 0;
  exp_t exp_q[$];
  logic        m_v, m_src;
  logic [4:0]  m_c, m_rn, m_rm, m_rd;
  logic [63:0] m_rnd, m_rmd, m_imm;
  logic [1:0]  m_op;
  logic [10:0] m_opc;
  logic [10:0] ops [4] = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rn_data(id_rn_data), .id_rm_data(id_rm_data), .id_imm(id_imm),
    .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd), .id_alu_op(id_alu_op),
    .id_alu_src(id_alu_src), .id_opcode(id_opcode), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .id_branch(id_branch), .exm_reg_write(exm_reg_write), .exm_rd(exm_rd),
    .exm_result(exm_result), .mwb_reg_write(mwb_reg_write), .mwb_rd(mwb_rd),
    .mwb_result(mwb_result), .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_illegal(ex_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] fwd(input logic [4:0] idx, input logic [63:0] d);
    if (idx != 5'd31 && exm_reg_write && exm_rd == idx) return exm_result;
    if (idx != 5'd31 && mwb_reg_write && mwb_rd == idx) return mwb_result;
    return d;
  endfunction

  // Model the coming clock edge, then the outputs the stage should show afterwards.
  task automatic predict();
    exp_t e;
    logic [63:0] rn_f, rm_f, b0;
    if (!rst_n) begin
      m_v = 0; m_c = 0; m_rnd = 0; m_rmd = 0; m_imm = 0; m_rn = 0; m_rm = 0; m_rd = 0;
      m_op = 0; m_src = 0; m_opc = 0;
    end else if (flush) begin
      m_v = 0; m_c = 0;
    end else if (!stall) begin
      m_v = id_valid; m_c = {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch};
      m_rnd = id_rn_data; m_rmd = id_rm_data; m_imm = id_imm; m_rn = id_rn; m_rm = id_rm;
      m_rd = id_rd; m_op = id_alu_op; m_src = id_alu_src; m_opc = id_opcode;
    end
    e = '0;
    if (m_v) begin
      rn_f = fwd(m_rn, m_rnd);
      rm_f = fwd(m_rm, m_rmd);
      b0 = m_src ? m_imm : rm_f;
      e.v = 1; e.sd = rm_f; e.rd = m_rd;
      {e.rw, e.mr, e.mw, e.mtr, e.br} = m_c;
      if (m_op == 0) begin e.sel = 2; e.a = rn_f; e.b = b0; end
      else if (m_op == 1) begin e.sel = 1; e.b = rm_f; end
      else if (m_op == 2 && m_opc == 11'b10001011000) begin e.sel = 2; e.a = rn_f; e.b = b0; end
      else if (m_op == 2 && m_opc == 11'b11001011000) begin e.sel = 2; e.a = rn_f; e.b = 64'd0 - b0; end
      else if (m_op == 2 && m_opc == 11'b10001010000) begin e.sel = 0; e.a = rn_f; e.b = b0; end
      else if (m_op == 2 && m_opc == 11'b10101010000) begin e.sel = 1; e.a = rn_f; e.b = b0; end
      else begin e.ill = 1; {e.rw, e.mr, e.mw, e.mtr, e.br} = 0; end
    end
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t got, e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        got = '{alu_a, alu_b, ex_store_data, alu_sel, ex_rd, ex_valid, ex_reg_write,
                ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch, ex_illegal};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL ex_outputs t=%0t: got a=%h b=%h sel=%b all=%h, expected a=%h b=%h sel=%b all=%h",
                   $time, got.a, got.b, got.sel, got, e.a, e.b, e.sel, e);
        end
      end
    end
  end

  task automatic idle_inputs();
    stall = 0; flush = 0; id_valid = 1; id_alu_src = 0; id_imm = 0;
    id_rn_data = 0; id_rm_data = 0; id_rn = 0; id_rm = 0; id_rd = 0;
    id_alu_op = 2; id_opcode = ops[0];
    {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch} = 5'b10000;
    exm_reg_write = 0; exm_rd = 0; exm_result = 0; mwb_reg_write = 0; mwb_rd = 0; mwb_result = 0;
  endtask

  function automatic logic [4:0] pick_idx();
    int k = $urandom_range(0, 5);
    return k == 5 ? 5'd31 : 5'(k);
  endfunction

  function automatic logic [63:0] pick_data();
    return $urandom_range(0, 3) == 0 ? 64'($urandom_range(0, 3)) : {$urandom, $urandom};
  endfunction

  initial begin
    rst_n = 0;
    idle_inputs();
    @(negedge clk); rst_n = 0; predict();
    @(negedge clk); rst_n = 1; id_rn = 5; id_rm = 9; id_rn_data = 3; id_rm_data = 4; id_rd = 1; predict();
    @(negedge clk); id_rn = 2; exm_reg_write = 1; exm_rd = 2; exm_result = 64'hAA;
    mwb_reg_write = 1; mwb_rd = 2; mwb_result = 64'hBB; predict();
    @(negedge clk); exm_reg_write = 0; predict();
    @(negedge clk); exm_reg_write = 1; id_rn = 31; exm_rd = 31; mwb_rd = 31; predict();
    @(negedge clk); exm_reg_write = 0; mwb_reg_write = 0; id_opcode = ops[1]; id_rm_data = 5; predict();
    @(negedge clk); id_alu_op = 0; id_alu_src = 1; id_imm = 16; id_mem_read = 1; id_mem_to_reg = 1; predict();
    @(negedge clk); id_alu_op = 2; id_opcode = ops[1]; id_alu_src = 0; id_rm_data = 0; predict();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); stall = 1; id_rn_data = pick_data(); id_opcode = ops[i]; id_rd = 5'(i + 7); predict();
    end
    @(negedge clk); flush = 1; predict();
    @(negedge clk); stall = 0; flush = 0; id_alu_op = 1; id_rm = 4; id_rm_data = 7;
    {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch} = 5'b00001; predict();
    @(negedge clk); id_alu_op = 2; id_opcode = 11'b11111111111;
    {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch} = 5'b11111; predict();
    @(negedge clk); id_alu_op = 3; id_opcode = ops[0]; predict();
    @(negedge clk); stall = 1; rst_n = 0; predict();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst_n = $urandom_range(0, 49) != 0;
      flush = $urandom_range(0, 9) == 0;
      stall = $urandom_range(0, 4) == 0;
      id_valid = $urandom_range(0, 7) != 0;
      id_rn = pick_idx(); id_rm = pick_idx(); id_rd = 5'($urandom_range(0, 31));
      id_rn_data = pick_data(); id_rm_data = pick_data(); id_imm = pick_data();
      id_alu_op = 2'($urandom_range(0, 3)); id_alu_src = 1'($urandom_range(0, 1));
      id_opcode = $urandom_range(0, 3) == 0 ? 11'($urandom) : ops[$urandom_range(0, 3)];
      {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch} = 5'($urandom);
      exm_reg_write = 1'($urandom_range(0, 1)); exm_rd = pick_idx(); exm_result = pick_data();
      mwb_reg_write = 1'($urandom_range(0, 1)); mwb_rd = pick_idx(); mwb_result = pick_data();
      predict();
    end
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
